// File: rtl/mac_result_drain.sv
// rtl/mac_result_drain.sv - snapshot one MAC row, clear it, stream results in cell order
// Optional MAC_DRAIN_SAT_EN: signed saturation to OUT_WIDTH plus sat_flag output.
module mac_result_drain #(
    parameter int NUM_CELLS = 4,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16,
    localparam int IDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_CELLS*ACC_WIDTH-1:0] acc_in,
    output logic                           acc_clr,
    output logic                           busy,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [OUT_WIDTH-1:0]           m_data,
    output logic [IDX_W-1:0]               m_index,
    output logic                           m_last,
    output logic                           done
`ifdef MAC_DRAIN_SAT_EN
    ,
    output logic                           sat_flag
`endif
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic                 acc_clr_q;
    logic                 done_q, done_d;
    logic [ACC_WIDTH-1:0] shadow_q [NUM_CELLS];
    logic [ACC_WIDTH-1:0] cur;
    logic                 capture;
    logic                 xfer;
    logic                 at_last;

    assign capture = (state_q == S_IDLE) && start;
    assign xfer    = (state_q == S_SEND) && m_ready;
    assign at_last = (index_q == IDX_W'(NUM_CELLS - 1));

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        done_d  = 1'b0;
        if (capture) begin
            state_d = S_SEND;
        end else if (xfer) begin
            if (at_last) begin
                state_d = S_IDLE;
                index_d = '0;
                done_d  = 1'b1;
            end else begin
                index_d = index_q + IDX_W'(1);
            end
        end
    end

    // Clear pulse comes straight from capture so output stalls never delay it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            acc_clr_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < NUM_CELLS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            acc_clr_q <= capture;
            done_q    <= done_d;
            if (capture) begin
                for (int i = 0; i < NUM_CELLS; i++) begin
                    shadow_q[i] <= acc_in[i*ACC_WIDTH +: ACC_WIDTH];
                end
            end
        end
    end

    assign cur     = shadow_q[index_q];
    assign acc_clr = acc_clr_q;
    assign done    = done_q;
    assign busy    = (state_q != S_IDLE);
    assign m_valid = (state_q == S_SEND);
    assign m_index = index_q;
    assign m_last  = m_valid && at_last;

`ifdef MAC_DRAIN_SAT_EN
    // Value fits when the dropped bits and the new sign bit all agree.
    logic [ACC_WIDTH-OUT_WIDTH:0] upper;
    logic                         clip;
    logic [OUT_WIDTH-1:0]         sat_val;

    assign upper    = cur[ACC_WIDTH-1:OUT_WIDTH-1];
    assign clip     = ~((&upper) | ~(|upper));
    assign sat_val  = cur[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                       : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    assign m_data   = clip ? sat_val : cur[OUT_WIDTH-1:0];
    assign sat_flag = m_valid && clip;
`else
    logic unused_upper;

    assign unused_upper = ^cur;
    assign m_data       = cur[OUT_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_mac_result_drain.sv
// tb/tb_mac_result_drain.sv - directed and randomized checks against a queue-based drain model
module tb_mac_result_drain;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int OW = 16;
    localparam int IW = 2;
    localparam longint MAXV = (64'sd1 <<< (OW - 1)) - 1;
    localparam longint MINV = -(MAXV + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [N*AW-1:0] acc_in;
    logic            acc_clr;
    logic            busy;
    logic            m_valid;
    logic            m_ready;
    logic [OW-1:0]   m_data;
    logic [IW-1:0]   m_index;
    logic            m_last;
    logic            done;
`ifdef MAC_DRAIN_SAT_EN
    logic            sat_flag;
`endif

    mac_result_drain #(.NUM_CELLS(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .acc_in  (acc_in),
        .acc_clr (acc_clr),
        .busy    (busy),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_index (m_index),
        .m_last  (m_last),
        .done    (done)
`ifdef MAC_DRAIN_SAT_EN
        ,
        .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] d;
        int            idx;
        logic          sat;
    } elem_t;

    elem_t exp_q[$];
    logic  exp_clr;
    logic  exp_done;
    int    n_checks;
    int    n_fail;
    int    valid_cycles;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [OW:0] ref_conv(input logic [AW-1:0] w);
`ifdef MAC_DRAIN_SAT_EN
        longint v;
        v = longint'($signed(w));
        if (v > MAXV) return {1'b1, OW'(MAXV)};
        if (v < MINV) return {1'b1, OW'(MINV)};
        return {1'b0, w[OW-1:0]};
`else
        return {1'b0, w[OW-1:0]};
`endif
    endfunction

    task automatic set_acc(input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3);
        acc_in = {a3, a2, a1, a0};
    endtask

    task automatic check_outputs();
        check("acc_clr", acc_clr, exp_clr);
        check("done", done, exp_done);
        check("busy", busy, exp_q.size() > 0);
        check("m_valid", m_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            valid_cycles++;
            check("m_data", m_data, exp_q[0].d);
            check("m_index", m_index, exp_q[0].idx);
            check("m_last", m_last, exp_q[0].idx == N - 1);
`ifdef MAC_DRAIN_SAT_EN
            check("sat_flag", sat_flag, exp_q[0].sat);
`endif
        end else begin
            check("m_last_idle", m_last, 1'b0);
        end
    endtask

    // Inputs change at the falling edge; the model advances on the rising edge.
    task automatic step(input logic st, input logic rdy);
        elem_t       e;
        logic [OW:0] c;
        start   = st;
        m_ready = rdy;
        @(posedge clk);
        exp_clr  = 1'b0;
        exp_done = 1'b0;
        if (exp_q.size() == 0) begin
            if (st) begin
                for (int i = 0; i < N; i++) begin
                    c     = ref_conv(acc_in[i*AW +: AW]);
                    e.d   = c[OW-1:0];
                    e.sat = c[OW];
                    e.idx = i;
                    exp_q.push_back(e);
                end
                exp_clr = 1'b1;
            end
        end else if (rdy) begin
            e = exp_q.pop_front();
            if (e.idx == N - 1) exp_done = 1'b1;
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        exp_clr = 1'b0;
        exp_done = 1'b0;
        rst = 1'b0;
        start = 1'b0;
        m_ready = 1'b0;
        acc_in = '0;
        repeat (2) @(negedge clk);
        check_outputs();
        check("rst_m_data", m_data, 0);
        check("rst_m_index", m_index, 0);
        rst = 1'b1;
        step(0, 1);

        // basic drain
        set_acc(32'd40, -32'sd3, 32'd7, 32'd1000);
        step(1, 1);
        check("basic_clr", acc_clr, 1'b1);
        check("basic_d0", m_data, 16'h0028);
        step(0, 1);
        check("basic_d1", m_data, 16'hFFFD);
        step(0, 1);
        check("basic_d2", m_data, 16'h0007);
        step(0, 1);
        check("basic_d3", m_data, 16'h03E8);
        check("basic_last", m_last, 1'b1);
        step(0, 1);
        check("basic_done", done, 1'b1);
        step(0, 1);

        // backpressure on index 1
        valid_cycles = 0;
        step(1, 1);
        step(0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            check("bp_hold_d", m_data, 16'hFFFD);
            check("bp_hold_i", m_index, 1);
            check("bp_clr", acc_clr, 1'b0);
        end
        step(0, 1);
        step(0, 1);
        step(0, 1);
        check("bp_drain_len", valid_cycles, 7);
        step(0, 1);

        // capture isolation and start while busy
        step(1, 1);
        set_acc(32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);
        for (int i = 0; i < 3; i++) step(1, 1);
        check("iso_d3", m_data, 16'h03E8);
        step(0, 1);
        step(0, 1);
        check("iso_idle", busy, 1'b0);

        // width conversion
        set_acc(32'h00012345, 32'hFFFF0000, 32'd7, 32'd0);
        step(1, 1);
`ifdef MAC_DRAIN_SAT_EN
        check("conv0", m_data, 16'h7FFF);
        check("conv0_sat", sat_flag, 1'b1);
        step(0, 1);
        check("conv1", m_data, 16'h8000);
        check("conv1_sat", sat_flag, 1'b1);
        step(0, 1);
        check("conv2_sat", sat_flag, 1'b0);
`else
        check("conv0", m_data, 16'h2345);
        step(0, 1);
        check("conv1", m_data, 16'h0000);
        step(0, 1);
`endif
        check("conv2", m_data, 16'h0007);
        step(0, 1);
        step(0, 1);

        // async reset mid-stream
        set_acc(32'd40, -32'sd3, 32'd7, 32'd1000);
        step(1, 1);
        step(0, 1);
        step(0, 1);
        check("rs_idx2", m_index, 2);
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        exp_clr = 1'b0;
        exp_done = 1'b0;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        step(0, 1);
        step(1, 1);
        check("rs_restart_idx", m_index, 0);
        check("rs_restart_d", m_data, 16'h0028);
        for (int i = 0; i < 4; i++) step(0, 1);
        check("rs_done", done, 1'b1);

        // back-to-back: start in the done cycle
        step(1, 1);
        for (int i = 0; i < 4; i++) step(0, 1);
        check("b2b_done", done, 1'b1);
        step(1, 1);
        check("b2b_clr", acc_clr, 1'b1);
        check("b2b_idx", m_index, 0);
        for (int i = 0; i < 4; i++) step(0, 1);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < N; i++) begin
                    case ($urandom_range(0, 2))
                        0: acc_in[i*AW +: AW] = 32'($signed($urandom_range(0, 200)) - 100);
                        1: acc_in[i*AW +: AW] = 32'($signed($urandom_range(0, 131072)) - 65536);
                        default: acc_in[i*AW +: AW] = $urandom;
                    endcase
                end
            end
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
